// File: rtl/update_point_batch.sv
// Batched point integrator: gravity on y-velocity, Euler position step and damped
// reflection at the world bounds, processed one point at a time over three cycles.
module update_point_batch #(
   parameter int DT            = 1,
   parameter int POSITION_SIZE = 8,
   parameter int VELOCITY_SIZE = 8,
   parameter int NUM_POINTS    = 4,
   parameter int GRAVITY       = -1,
   parameter int DAMP_SHIFT    = 1,
   parameter int X_MIN         = -10,
   parameter int X_MAX         = 10,
   parameter int Y_MIN         = -10,
   parameter int Y_MAX         = 10
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            begin_in,
   input  logic signed [POSITION_SIZE-1:0] pos_x_in  [NUM_POINTS],
   input  logic signed [POSITION_SIZE-1:0] pos_y_in  [NUM_POINTS],
   input  logic signed [VELOCITY_SIZE-1:0] vel_x_in  [NUM_POINTS],
   input  logic signed [VELOCITY_SIZE-1:0] vel_y_in  [NUM_POINTS],
   input  logic        [NUM_POINTS-1:0]    pin_mask_in,
   output logic signed [POSITION_SIZE-1:0] new_pos_x [NUM_POINTS],
   output logic signed [POSITION_SIZE-1:0] new_pos_y [NUM_POINTS],
   output logic signed [VELOCITY_SIZE-1:0] new_vel_x [NUM_POINTS],
   output logic signed [VELOCITY_SIZE-1:0] new_vel_y [NUM_POINTS],
   output logic                            result_out,
   output logic                            busy_out
);

   typedef enum logic [2:0] {IDLE, VEL, POS, BOUND, DONE} state_t;

   localparam int IDX_W  = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
   localparam int SUM_W  = POSITION_SIZE + VELOCITY_SIZE + $clog2(DT + 1) + 2;
   localparam int VSUM_W = ((VELOCITY_SIZE > 32) ? VELOCITY_SIZE : 32) + 2;

   localparam logic signed [VSUM_W-1:0] V_HI = {{(VSUM_W-VELOCITY_SIZE+1){1'b0}}, {(VELOCITY_SIZE-1){1'b1}}};
   localparam logic signed [VSUM_W-1:0] V_LO = {{(VSUM_W-VELOCITY_SIZE+1){1'b1}}, {(VELOCITY_SIZE-1){1'b0}}};
   localparam logic signed [SUM_W-1:0]  P_HI = {{(SUM_W-POSITION_SIZE+1){1'b0}}, {(POSITION_SIZE-1){1'b1}}};
   localparam logic signed [SUM_W-1:0]  P_LO = {{(SUM_W-POSITION_SIZE+1){1'b1}}, {(POSITION_SIZE-1){1'b0}}};
   localparam logic signed [VSUM_W-1:0] GRAV_STEP = VSUM_W'(GRAVITY * DT);
   localparam logic signed [SUM_W-1:0]  DT_W      = SUM_W'(DT);
   localparam logic signed [POSITION_SIZE-1:0] X_LO = POSITION_SIZE'(X_MIN);
   localparam logic signed [POSITION_SIZE-1:0] X_HI = POSITION_SIZE'(X_MAX);
   localparam logic signed [POSITION_SIZE-1:0] Y_LO = POSITION_SIZE'(Y_MIN);
   localparam logic signed [POSITION_SIZE-1:0] Y_HI = POSITION_SIZE'(Y_MAX);

   function automatic logic signed [VELOCITY_SIZE-1:0] sat_v(input logic signed [VSUM_W-1:0] v);
      logic signed [VSUM_W-1:0] r;
      r = v;
      if (v > V_HI) r = V_HI;
      else if (v < V_LO) r = V_LO;
      return r[VELOCITY_SIZE-1:0];
   endfunction

   function automatic logic signed [POSITION_SIZE-1:0] sat_p(input logic signed [SUM_W-1:0] p);
      logic signed [SUM_W-1:0] r;
      r = p;
      if (p > P_HI) r = P_HI;
      else if (p < P_LO) r = P_LO;
      return r[POSITION_SIZE-1:0];
   endfunction

   // Negation is done wide so the most negative value saturates instead of wrapping.
   function automatic logic signed [VELOCITY_SIZE-1:0] reflect_v(input logic signed [VELOCITY_SIZE-1:0] v);
      logic signed [VSUM_W-1:0] w;
      w = VSUM_W'(v) >>> DAMP_SHIFT;
      return sat_v(-w);
   endfunction

   state_t                          state_reg, state_next;
   logic [IDX_W-1:0]                idx_reg;
   logic signed [POSITION_SIZE-1:0] px_reg [NUM_POINTS];
   logic signed [POSITION_SIZE-1:0] py_reg [NUM_POINTS];
   logic signed [VELOCITY_SIZE-1:0] vx_reg [NUM_POINTS];
   logic signed [VELOCITY_SIZE-1:0] vy_reg [NUM_POINTS];
   logic [NUM_POINTS-1:0]           pin_reg;
   logic signed [VELOCITY_SIZE-1:0] vy_step_reg;
   logic signed [POSITION_SIZE-1:0] px_step_reg, py_step_reg;

   logic [NUM_POINTS-1:0]           sel;
   logic signed [POSITION_SIZE-1:0] px_cur, py_cur, px_wb, py_wb;
   logic signed [VELOCITY_SIZE-1:0] vx_cur, vy_cur, vx_wb, vy_wb;
   logic                            pin_cur, last_point;

   for (genvar gi = 0; gi < NUM_POINTS; gi++) begin : g_sel
      assign sel[gi] = (idx_reg == IDX_W'(gi));
   end

   assign last_point = (idx_reg == IDX_W'(NUM_POINTS - 1));

   always_comb begin
      px_cur  = '0;
      py_cur  = '0;
      vx_cur  = '0;
      vy_cur  = '0;
      pin_cur = 1'b0;
      for (int i = 0; i < NUM_POINTS; i++) begin
         if (sel[i]) begin
            px_cur  = px_reg[i];
            py_cur  = py_reg[i];
            vx_cur  = vx_reg[i];
            vy_cur  = vy_reg[i];
            pin_cur = pin_reg[i];
         end
      end
   end

   always_comb begin
      px_wb = px_step_reg;
      vx_wb = vx_cur;
      py_wb = py_step_reg;
      vy_wb = vy_step_reg;
      if (px_step_reg < X_LO || px_step_reg > X_HI) begin
         px_wb = (px_step_reg < X_LO) ? X_LO : X_HI;
         vx_wb = reflect_v(vx_cur);
      end
      if (py_step_reg < Y_LO || py_step_reg > Y_HI) begin
         py_wb = (py_step_reg < Y_LO) ? Y_LO : Y_HI;
         vy_wb = reflect_v(vy_step_reg);
      end
      if (pin_cur) begin
         px_wb = px_cur;
         py_wb = py_cur;
         vx_wb = vx_cur;
         vy_wb = vy_cur;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (begin_in) state_next = VEL;
         VEL:     state_next = POS;
         POS:     state_next = BOUND;
         BOUND:   state_next = last_point ? DONE : VEL;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The final write-back is merged into the outputs so they are valid while result_out is high.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         idx_reg     <= '0;
         pin_reg     <= '0;
         vy_step_reg <= '0;
         px_step_reg <= '0;
         py_step_reg <= '0;
         for (int i = 0; i < NUM_POINTS; i++) begin
            px_reg[i]    <= '0;
            py_reg[i]    <= '0;
            vx_reg[i]    <= '0;
            vy_reg[i]    <= '0;
            new_pos_x[i] <= '0;
            new_pos_y[i] <= '0;
            new_vel_x[i] <= '0;
            new_vel_y[i] <= '0;
         end
      end else begin
         case (state_reg)
            IDLE: if (begin_in) begin
               idx_reg <= '0;
               pin_reg <= pin_mask_in;
               for (int i = 0; i < NUM_POINTS; i++) begin
                  px_reg[i] <= pos_x_in[i];
                  py_reg[i] <= pos_y_in[i];
                  vx_reg[i] <= vel_x_in[i];
                  vy_reg[i] <= vel_y_in[i];
               end
            end
            VEL: vy_step_reg <= sat_v(VSUM_W'(vy_cur) + GRAV_STEP);
            POS: begin
               px_step_reg <= sat_p(SUM_W'(px_cur) + SUM_W'(vx_cur) * DT_W);
               py_step_reg <= sat_p(SUM_W'(py_cur) + SUM_W'(vy_step_reg) * DT_W);
            end
            BOUND: begin
               for (int i = 0; i < NUM_POINTS; i++) begin
                  if (sel[i]) begin
                     px_reg[i] <= px_wb;
                     py_reg[i] <= py_wb;
                     vx_reg[i] <= vx_wb;
                     vy_reg[i] <= vy_wb;
                  end
                  if (last_point) begin
                     new_pos_x[i] <= sel[i] ? px_wb : px_reg[i];
                     new_pos_y[i] <= sel[i] ? py_wb : py_reg[i];
                     new_vel_x[i] <= sel[i] ? vx_wb : vx_reg[i];
                     new_vel_y[i] <= sel[i] ? vy_wb : vy_reg[i];
                  end
               end
               if (!last_point) idx_reg <= idx_reg + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign result_out = (state_reg == DONE);
   assign busy_out   = (state_reg != IDLE);

endmodule

// File: tb/tb_update_point_batch.sv
// Directed bench for update_point_batch: default 4-point build plus a 1-point DT=2 build,
// checking latency, pulse count, busy/reset behaviour and hand-computed results.
module tb_update_point_batch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, begin_s, begin2;
   logic signed [7:0] pos_x [4], pos_y [4], vel_x [4], vel_y [4];
   logic [3:0]        pin;
   logic signed [7:0] npx [4], npy [4], nvx [4], nvy [4];
   logic              result, busy;

   logic signed [7:0] p2x [1], p2y [1], v2x [1], v2y [1];
   logic [0:0]        pin2;
   logic signed [7:0] n2px [1], n2py [1], n2vx [1], n2vy [1];
   logic              result2, busy2;

   update_point_batch dut (
      .clk_in(clk), .rst_in(rst), .begin_in(begin_s),
      .pos_x_in(pos_x), .pos_y_in(pos_y), .vel_x_in(vel_x), .vel_y_in(vel_y),
      .pin_mask_in(pin),
      .new_pos_x(npx), .new_pos_y(npy), .new_vel_x(nvx), .new_vel_y(nvy),
      .result_out(result), .busy_out(busy)
   );

   update_point_batch #(.NUM_POINTS(1), .DT(2)) dut2 (
      .clk_in(clk), .rst_in(rst), .begin_in(begin2),
      .pos_x_in(p2x), .pos_y_in(p2y), .vel_x_in(v2x), .vel_y_in(v2y),
      .pin_mask_in(pin2),
      .new_pos_x(n2px), .new_pos_y(n2py), .new_vel_x(n2vx), .new_vel_y(n2vy),
      .result_out(result2), .busy_out(busy2)
   );

   int errors = 0;
   int checks = 0;
   int exp_px [4], exp_py [4], exp_vx [4], exp_vy [4];
   int first_res, n_res;
   logic busy_at1, snap_busy;
   int snap_px0;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_point(input int i, input int px, input int py, input int vx, input int vy,
                            input int ex_px, input int ex_py, input int ex_vx, input int ex_vy);
      pos_x[i] = 8'(px);
      pos_y[i] = 8'(py);
      vel_x[i] = 8'(vx);
      vel_y[i] = 8'(vy);
      exp_px[i] = ex_px;
      exp_py[i] = ex_py;
      exp_vx[i] = ex_vx;
      exp_vy[i] = ex_vy;
   endtask

   // Point 0 nominal, point 1 floor hit, point 2 saturation, point 3 corner hit.
   task automatic load_set_a();
      pin = 4'b0000;
      set_point(0, 2, 3, -1, 0,      1, 2, -1, -1);
      set_point(1, 0, -9, 0, -4,     0, -10, 0, 3);
      set_point(2, 0, 0, 0, -128,    0, -10, 0, 64);
      set_point(3, 9, 9, 5, 5,       10, 10, -2, -2);
   endtask

   task automatic check_outputs(input string pfx);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_px%0d", pfx, i), npx[i], exp_px[i]);
         check($sformatf("%s_py%0d", pfx, i), npy[i], exp_py[i]);
         check($sformatf("%s_vx%0d", pfx, i), nvx[i], exp_vx[i]);
         check($sformatf("%s_vy%0d", pfx, i), nvy[i], exp_vy[i]);
      end
   endtask

   // Cycle 0 carries the begin pulse; every later cycle is sampled on the falling edge.
   task automatic run_batch(input bit use2, input int b2, input int rc, input int ncyc, input bit scramble);
      logic r;
      first_res = -1;
      n_res     = 0;
      @(posedge clk); #1;
      if (use2) begin2 = 1'b1; else begin_s = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk); #1;
         begin_s = 1'b0;
         begin2  = 1'b0;
         rst     = (k == rc);
         if (k == b2) begin
            if (use2) begin2 = 1'b1; else begin_s = 1'b1;
         end
         if (scramble && k == 1) begin
            pos_x[0] = 8'sd50;
            vel_y[3] = -8'sd77;
         end
         @(negedge clk);
         r = use2 ? result2 : result;
         if (r) begin
            n_res++;
            if (first_res < 0) first_res = k;
         end
         if (k == 1) busy_at1 = use2 ? busy2 : busy;
         if (rc != 0 && k == rc + 1) begin
            snap_busy = busy;
            snap_px0  = int'(npx[0]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; begin_s = 1'b0; begin2 = 1'b0; pin = '0; pin2 = '0;
      for (int i = 0; i < 4; i++) begin
         pos_x[i] = '0; pos_y[i] = '0; vel_x[i] = '0; vel_y[i] = '0;
      end
      p2x[0] = 8'sd9; p2y[0] = 8'sd0; v2x[0] = 8'sd2; v2y[0] = 8'sd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_npx0", npx[0], 0);
      check("rst_nvy3", nvy[3], 0);
      check("rst_n2px", n2px[0], 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Nominal batch; begin in the DONE cycle must be ignored.
      load_set_a();
      run_batch(1'b0, 13, 0, 30, 1'b0);
      check("a_latency", first_res, 13);
      check("a_pulses", n_res, 1);
      check("a_busy1", busy_at1, 1);
      check_outputs("a");
      repeat (3) @(negedge clk);
      check("a_hold_py1", npy[1], -10);
      check("a_hold_result", result, 0);

      // Pinned point 1, begin while busy, inputs changed after latch.
      load_set_a();
      pin = 4'b0010;
      set_point(1, 5, 5, 3, 3,   5, 5, 3, 3);
      run_batch(1'b0, 5, 0, 25, 1'b1);
      check("b_latency", first_res, 13);
      check("b_pulses", n_res, 1);
      check_outputs("b");

      // Reset mid-batch at cycle 6, restart at cycle 8.
      load_set_a();
      run_batch(1'b0, 8, 6, 30, 1'b0);
      check("c_rst_busy", snap_busy, 0);
      check("c_rst_npx0", snap_px0, 0);
      check("c_latency", first_res, 21);
      check("c_pulses", n_res, 1);
      check_outputs("c");

      // Reset wins over a simultaneous begin.
      @(posedge clk); #1;
      rst = 1'b1; begin_s = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; begin_s = 1'b0;
      @(negedge clk);
      check("d_busy", busy, 0);
      check("d_npx0", npx[0], 0);

      // Single-point DT=2 build: px' = 13 clamps to 10, py' = 0 + (-2)*2 = -4.
      run_batch(1'b1, 0, 0, 10, 1'b0);
      check("e_latency", first_res, 4);
      check("e_pulses", n_res, 1);
      check("e_px", n2px[0], 10);
      check("e_py", n2py[0], -4);
      check("e_vx", n2vx[0], -1);
      check("e_vy", n2vy[0], -2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
